// File: rtl/mixcol_pkg.sv
// Shared types and GF(2^8) helpers for the mix-columns engine.
// Inverse-coefficient multipliers are only built when MIXCOL_INV_EN is defined.
package mixcol_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] GF_POLY = 8'h1B;

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] a);
      return gf_xtime(a);
   endfunction

   function automatic logic [7:0] gf_mul3(input logic [7:0] a);
      return gf_xtime(a) ^ a;
   endfunction

`ifdef MIXCOL_INV_EN
   function automatic logic [7:0] gf_mul9(input logic [7:0] a);
      logic [7:0] x8;
      x8 = gf_xtime(gf_xtime(gf_xtime(a)));
      return x8 ^ a;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] a);
      logic [7:0] x2;
      logic [7:0] x8;
      x2 = gf_xtime(a);
      x8 = gf_xtime(gf_xtime(x2));
      return x8 ^ x2 ^ a;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] a);
      logic [7:0] x4;
      logic [7:0] x8;
      x4 = gf_xtime(gf_xtime(a));
      x8 = gf_xtime(x4);
      return x8 ^ x4 ^ a;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] a);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = gf_xtime(a);
      x4 = gf_xtime(x2);
      x8 = gf_xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction
`endif

endpackage

// File: rtl/mixcol_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column (row r at bits 8r+:8).
// The inverse path exists only when MIXCOL_INV_EN is defined; otherwise inv is ignored.
module mixcol_column
   import mixcol_pkg::*;
(
   input  logic [31:0] col_in,
   input  logic        inv,
   output logic [31:0] col_out
);

   logic [7:0] a   [4];
   logic [7:0] fwd [4];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         a[r] = col_in[8*r +: 8];
      end
   end

   // Each output row uses the same coefficient row, rotated by its index.
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         fwd[r] = gf_mul2(a[r]) ^ gf_mul3(a[2'(r+1)]) ^ a[2'(r+2)] ^ a[2'(r+3)];
      end
   end

`ifdef MIXCOL_INV_EN
   logic [7:0] bwd [4];

   always_comb begin
      for (int r = 0; r < 4; r++) begin
         bwd[r] = gf_mule(a[r]) ^ gf_mulb(a[2'(r+1)]) ^ gf_muld(a[2'(r+2)]) ^ gf_mul9(a[2'(r+3)]);
      end
   end

   always_comb begin
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
         col_out[8*r +: 8] = inv ? bwd[r] : fwd[r];
      end
   end
`else
   logic unused_inv;
   assign unused_inv = inv;

   always_comb begin
      col_out = '0;
      for (int r = 0; r < 4; r++) begin
         col_out[8*r +: 8] = fwd[r];
      end
   end
`endif

endmodule

// File: rtl/mixcol_engine.sv
// Sequential MixColumns engine: COLS_PER_CYCLE columns per clock over an NB-column state.
// Define MIXCOL_INV_EN to build the InvMixColumns path selected by mixcol_inv.
module mixcol_engine
   import mixcol_pkg::*;
#(
   parameter int NB             = 4,
   parameter int COLS_PER_CYCLE = 1
)
(
   input  logic            clk,
   input  logic            n_rst,
   input  logic            mixcol_enable,
   input  logic            mixcol_inv,
   input  logic [32*NB-1:0] olddata,
   output logic [32*NB-1:0] newdata,
   output logic            mixcol_busy,
   output logic            mixcol_finished
);

   localparam int N     = NB / COLS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int W     = 32 * NB;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   if (!((NB == 4) || (NB == 6) || (NB == 8))) begin : g_bad_nb
      $error("mixcol_engine: NB must be 4, 6 or 8");
   end
   if ((COLS_PER_CYCLE < 1) || ((NB % COLS_PER_CYCLE) != 0)) begin : g_bad_cpc
      $error("mixcol_engine: COLS_PER_CYCLE must divide NB");
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     work_q, work_d;
   logic [W-1:0]     newdata_q, newdata_d;
   logic             mode_q;

   logic [31:0] col_in  [COLS_PER_CYCLE];
   logic [31:0] col_out [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
   logic mode_d;
`else
   logic unused_inv;
   assign unused_inv = mixcol_inv;
   assign mode_q     = 1'b0;
`endif

   // Gather the current group of columns out of the row-major working register.
   always_comb begin : gather
      int base;
      base = int'(cnt_q) * COLS_PER_CYCLE;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         col_in[k] = '0;
         for (int r = 0; r < 4; r++) begin
            col_in[k][8*r +: 8] = work_q[8*(NB*r + base + k) +: 8];
         end
      end
   end

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      mixcol_column u_col (
         .col_in  (col_in[k]),
         .inv     (mode_q),
         .col_out (col_out[k])
      );
   end

   always_comb begin : next_state
      int base;
      state_d   = state_q;
      cnt_d     = cnt_q;
      work_d    = work_q;
      newdata_d = newdata_q;
`ifdef MIXCOL_INV_EN
      mode_d    = mode_q;
`endif
      base      = int'(cnt_q) * COLS_PER_CYCLE;
      case (state_q)
         IDLE, DONE: begin
            if (mixcol_enable) begin
               state_d = RUN;
               cnt_d   = '0;
               work_d  = olddata;
`ifdef MIXCOL_INV_EN
               mode_d  = mixcol_inv;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               for (int r = 0; r < 4; r++) begin
                  work_d[8*(NB*r + base + k) +: 8] = col_out[k][8*r +: 8];
               end
            end
            // Publish the whole state at once so newdata never shows a partial result.
            if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               cnt_d     = '0;
               newdata_d = work_d;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         newdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         work_q    <= work_d;
         newdata_q <= newdata_d;
      end
   end

`ifdef MIXCOL_INV_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mode_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
      end
   end
`endif

   assign newdata         = newdata_q;
   assign mixcol_busy     = (state_q == RUN);
   assign mixcol_finished = (state_q == DONE);

endmodule

// File: tb/tb_mixcol_engine.sv
// Directed bench for mixcol_engine: default, COLS_PER_CYCLE=2/4 and NB=8 instances.
`timescale 1ns/1ps
module tb_mixcol_engine;

   logic         clk = 1'b0;
   logic         n_rst;
   logic [3:0]   en;
   logic         inv;
   logic [255:0] od;
   logic [127:0] nd0, nd1, nd2;
   logic [255:0] nd3;
   logic [3:0]   busy, fin;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   mixcol_engine #(.NB(4), .COLS_PER_CYCLE(1)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .mixcol_enable(en[0]), .mixcol_inv(inv),
      .olddata(od[127:0]), .newdata(nd0), .mixcol_busy(busy[0]), .mixcol_finished(fin[0]));
   mixcol_engine #(.NB(4), .COLS_PER_CYCLE(2)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .mixcol_enable(en[1]), .mixcol_inv(inv),
      .olddata(od[127:0]), .newdata(nd1), .mixcol_busy(busy[1]), .mixcol_finished(fin[1]));
   mixcol_engine #(.NB(4), .COLS_PER_CYCLE(4)) u_dut2 (
      .clk(clk), .n_rst(n_rst), .mixcol_enable(en[2]), .mixcol_inv(inv),
      .olddata(od[127:0]), .newdata(nd2), .mixcol_busy(busy[2]), .mixcol_finished(fin[2]));
   mixcol_engine #(.NB(8), .COLS_PER_CYCLE(1)) u_dut3 (
      .clk(clk), .n_rst(n_rst), .mixcol_enable(en[3]), .mixcol_inv(inv),
      .olddata(od), .newdata(nd3), .mixcol_busy(busy[3]), .mixcol_finished(fin[3]));

   typedef struct {
      logic [127:0] din;
      logic         iv;
      logic [127:0] exp;
      string        name;
   } vec_t;

   // Columns are written a0,a1,a2,a3 from most to least significant byte.
   function automatic logic [127:0] st4(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
      logic [31:0]  c [4];
      logic [127:0] s;
      c = '{c0, c1, c2, c3};
      s = '0;
      for (int col = 0; col < 4; col++)
         for (int r = 0; r < 4; r++)
            s[8*(4*r + col) +: 8] = c[col][8*(3-r) +: 8];
      return s;
   endfunction

   function automatic logic [255:0] col8(input int col, input logic [31:0] v);
      logic [255:0] s;
      s = '0;
      for (int r = 0; r < 4; r++)
         s[8*(8*r + col) +: 8] = v[8*(3-r) +: 8];
      return s;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] out_of(input int d);
      case (d)
         0:       return {128'b0, nd0};
         1:       return {128'b0, nd1};
         2:       return {128'b0, nd2};
         default: return nd3;
      endcase
   endfunction

   // Starts an operation from IDLE at a negedge; lat counts edges from start to finished.
   task automatic run(input int d, input logic [255:0] din, input logic iv,
                      output logic [255:0] dout, output int lat);
      od    = din;
      inv   = iv;
      en[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[d] = 1'b0;
      chk("busy_after_start", {255'b0, busy[d]}, 256'd1);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!fin[d] && lat < 20);
      dout = out_of(d);
      @(posedge clk);
      @(negedge clk);
      chk("finished_one_cycle", {255'b0, fin[d]}, 256'd0);
   endtask

   vec_t         tbl [6];
   logic [255:0] res, res2, prev, rnd;
   int           lat;
   int           pulses;
   int           first_at, second_at, third_at;
   int           waited;

   localparam logic [127:0] FOUR_IN  = 128'h0;
   logic [127:0] four_in, four_out;

   initial begin
      four_in  = st4(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h2d26314c);
      four_out = st4(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h4d7ebdf8);
      tbl[0] = '{st4(32'hdb135345, 0, 0, 0), 1'b0, st4(32'h8e4da1bc, 0, 0, 0), "fwd_col0"};
      tbl[1] = '{four_in, 1'b0, four_out, "fwd_four_cols"};
      tbl[2] = '{128'h0, 1'b0, 128'h0, "fwd_zero"};
      tbl[3] = '{{128{1'b1}}, 1'b0, {128{1'b1}}, "fwd_all_ff"};
`ifdef MIXCOL_INV_EN
      tbl[4] = '{st4(32'h8e4da1bc, 0, 0, 0), 1'b1, st4(32'hdb135345, 0, 0, 0), "inv_col0"};
      tbl[5] = '{four_out, 1'b1, four_in, "inv_four_cols"};
`else
      tbl[4] = '{st4(32'hdb135345, 0, 0, 0), 1'b1, st4(32'h8e4da1bc, 0, 0, 0), "inv_ignored_col0"};
      tbl[5] = '{four_in, 1'b1, four_out, "inv_ignored_four"};
`endif

      n_rst = 1'b0;
      en    = '0;
      inv   = 1'b0;
      od    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_newdata", {128'b0, nd0}, 256'd0);
      chk("reset_newdata_nb8", nd3, 256'd0);
      chk("reset_busy", {252'b0, busy}, 256'd0);
      chk("reset_finished", {252'b0, fin}, 256'd0);
      n_rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run(0, {128'b0, tbl[i].din}, tbl[i].iv, res, lat);
         chk(tbl[i].name, res, {128'b0, tbl[i].exp});
         chk("latency_cpc1", 256'(lat), 256'd4);
      end

      run(1, {128'b0, four_in}, 1'b0, res, lat);
      chk("fwd_cpc2", res, {128'b0, four_out});
      chk("latency_cpc2", 256'(lat), 256'd2);
      run(2, {128'b0, four_in}, 1'b0, res, lat);
      chk("fwd_cpc4", res, {128'b0, four_out});
      chk("latency_cpc4", 256'(lat), 256'd1);
      run(3, col8(7, 32'hd4d4d4d5), 1'b0, res, lat);
      chk("fwd_nb8_col7", res, col8(7, 32'hd5d5d7d6));
      chk("latency_nb8", 256'(lat), 256'd8);

`ifdef MIXCOL_INV_EN
      rnd = {128'b0, $urandom(), $urandom(), $urandom(), $urandom()};
      run(0, rnd, 1'b0, res, lat);
      run(0, res, 1'b1, res2, lat);
      chk("roundtrip_random", res2, rnd);
`endif

      // Enable held high: finished should recur every N+1 = 5 cycles.
      od       = {128'b0, st4(32'hdb135345, 0, 0, 0)};
      inv      = 1'b0;
      en[0]    = 1'b1;
      pulses   = 0;
      first_at = 0; second_at = 0; third_at = 0;
      for (int c = 1; c <= 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (fin[0]) begin
            pulses++;
            if (pulses == 1) first_at = c;
            if (pulses == 2) second_at = c;
            if (pulses == 3) third_at = c;
            chk("b2b_result", {128'b0, nd0}, {128'b0, st4(32'h8e4da1bc, 0, 0, 0)});
         end
      end
      en[0] = 1'b0;
      chk("b2b_pulse_count", 256'(pulses), 256'd3);
      chk("b2b_first", 256'(first_at), 256'd5);
      chk("b2b_period", 256'(second_at - first_at), 256'd5);
      chk("b2b_period2", 256'(third_at - second_at), 256'd5);
      waited = 0;
      while ((busy[0] || fin[0]) && waited < 20) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      chk("b2b_drain", {255'b0, busy[0] | fin[0]}, 256'd0);

      // Start pulse during RUN is dropped and newdata holds until finished.
      prev  = {128'b0, nd0};
      od    = {128'b0, four_in};
      en[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      od    = {128'b0, st4(32'hdb135345, 0, 0, 0)};
      en[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[0] = 1'b0;
      chk("hold_during_run", {128'b0, nd0}, prev);
      waited = 0;
      while (!fin[0] && waited < 20) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      chk("run_pulse_result", {128'b0, nd0}, {128'b0, four_out});
      chk("run_pulse_wait", 256'(waited), 256'd2);
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk("run_pulse_not_queued", {254'b0, busy[0], fin[0]}, 256'd0);
      end

      // Asynchronous reset in the middle of RUN.
      od    = {128'b0, four_in};
      en[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1 n_rst = 1'b0;
      #1;
      chk("midrun_reset_newdata", {128'b0, nd0}, 256'd0);
      chk("midrun_reset_ctrl", {254'b0, busy[0], fin[0]}, 256'd0);
      @(posedge clk);
      @(negedge clk);
      n_rst  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (fin[0] || busy[0]) pulses++;
      end
      chk("no_finish_after_reset", 256'(pulses), 256'd0);
      run(0, {128'b0, st4(32'hdb135345, 0, 0, 0)}, 1'b0, res, lat);
      chk("after_reset_result", res, {128'b0, st4(32'h8e4da1bc, 0, 0, 0)});
      chk("after_reset_latency", 256'(lat), 256'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mixcol_engine.md
# mixcol_engine

Parametrised, sequential successor to the combinational mix-columns stage. Applies the AES MixColumns transform, or InvMixColumns when compiled in, to a state of NB 32-bit columns, processing COLS_PER_CYCLE columns per clock. Uses the existing enable/finished handshake so the round controller can trade area for latency without changing its sequencing.

## Interface
- NB, 4: number of 32-bit columns in the state; legal values 4, 6, 8.
- COLS_PER_CYCLE, 1: columns transformed per clock; must divide NB, otherwise elaboration fails.
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- mixcol_enable  input  1  start request; sampled only in IDLE or DONE.
- mixcol_inv  input  1  1 = InvMixColumns; sampled with the start request.
- olddata  input  32*NB  input state; sampled with the start request.
- newdata  output  32*NB  registered result; held stable until the next accepted start.
- mixcol_busy  output  1  high in RUN.
- mixcol_finished  output  1  one-cycle pulse; newdata is valid from this cycle on.

## Operation
- Byte layout: row r, column c sits at bit offset 8*(NB*r + c). Column c consists of rows 0..3 at those offsets.
- Forward transform per column (a0..a3 → b0..b3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Inverse transform uses coefficients 0e, 0b, 0d, 09, rotated the same way.
- Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B): xtime = shift left 1, then XOR 0x1B if the old bit 7 was set. Integer multiply is forbidden. All products are 8 bits.
- States:
  - IDLE: accept start.
  - RUN: transform COLS_PER_CYCLE columns per clock, starting at column 0 and ascending. The column counter has width clog2(NB/COLS_PER_CYCLE) bits.
  - DONE: mixcol_finished = 1 for one cycle.
- Transitions:
  - IDLE→RUN on mixcol_enable. olddata is latched into a working register and mixcol_inv into the mode flag.
  - RUN→RUN while the counter is below N-1, where N = NB/COLS_PER_CYCLE.
  - RUN→DONE after group N-1 is written.
  - DONE→RUN if mixcol_enable is high (back-to-back operation), else DONE→IDLE.
- mixcol_enable during RUN is ignored; it is not queued.
- Transformed columns are written in place into the working register. newdata is updated from the working register in one step on the RUN→DONE edge, so newdata never shows a partial result.

## Timing
- Reset values: state IDLE, counter 0, newdata 0, mixcol_busy 0, mixcol_finished 0, working register 0.
- If start is sampled at edge E0, mixcol_busy is high for cycles E0..E0+N-1. mixcol_finished is high exactly for the cycle following edge E0+N. Latency from start to finished is N clocks: 4 at the defaults, 1 with NB=4 and COLS_PER_CYCLE=4.
- Back-to-back: a start sampled in DONE makes the next finished appear N cycles later. Throughput is one state per N+1 cycles.
- Reset asserted mid-RUN: asynchronous clear to the reset values. No finished pulse; any partial result is discarded.
- mixcol_inv and olddata are don't-care outside the start cycle.

## Configuration
- MIXCOL_INV_EN defined: the inverse coefficient path is built, and mixcol_inv selects the mode per operation.
- MIXCOL_INV_EN undefined: the port remains but is ignored, the mode flag is tied to 0, and only the forward path is synthesised.

## Structure
- Package mixcol_pkg:
  - state enum (IDLE, RUN, DONE)
  - GF_POLY = 8'h1B
  - functions gf_xtime, gf_mul2, gf_mul3
  - gf_mul9, gf_mulb, gf_muld, gf_mule, built under MIXCOL_INV_EN
- Sub-module mixcol_column: combinational single-column transform with inputs col_in[31:0] and inv, output col_out[31:0]. It is instantiated COLS_PER_CYCLE times. The top level holds the FSM, counter, working register and output register.

## Test plan
- Forward, defaults: column 0 = db,13,53,45 (rows 0..3), other columns 00 → column 0 = 8e,4d,a1,bc and others 00. finished pulses 4 cycles after start, one cycle wide.
- Forward: columns f2,0a,22,5c / 01,01,01,01 / c6,c6,c6,c6 / 2d,26,31,4c → 9f,dc,58,9d / 01,01,01,01 / c6,c6,c6,c6 / 4d,7e,bd,f8. Repeat with COLS_PER_CYCLE=2 and 4; latency must be 2 and 1.
- Inverse (MIXCOL_INV_EN): column 8e,4d,a1,bc with inv=1 → db,13,53,45. A random 128-bit state run forward then inverse must return the original.
- Handshake: hold mixcol_enable high continuously → one finished every 5 cycles (defaults). A pulse during RUN is ignored, and newdata does not change until finished.
- Reset: drop n_rst two cycles after start → outputs 0 immediately with no finished. After release, a new operation completes correctly.
- NB=8: column 7 = d4,d4,d4,d5 → d5,d5,d7,d6 at the row-major offsets, with latency 8.
